// File: rtl/dsc_pkg.sv
// rtl/dsc_pkg.sv - shared state encoding and parameter limits for the stochastic multiplier
package dsc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dsc_state_t;

    localparam int N_IN_MIN     = 2;
    localparam int N_IN_MAX     = 4;
    localparam int NUM_BITS_MIN = 2;
    localparam int NUM_BITS_MAX = 12;

endpackage

// File: rtl/dsc_prg_ch.sv
// rtl/dsc_prg_ch.sv - one multiplicand channel: operand latch, chained counter, comparator
module dsc_prg_ch #(
    parameter int NUM_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic                run,
    input  logic                carry_in,
    input  logic [NUM_BITS-1:0] a_in,
    output logic                s,
    output logic                tc
);

    logic [NUM_BITS-1:0] op;
    logic [NUM_BITS-1:0] ctr;

    // Latch the operand on an accepted start; count only when every lower channel has wrapped
    always_ff @(posedge clk) begin
        if (rst) begin
            op  <= '0;
            ctr <= '0;
        end else if (en) begin
            if (load) begin
                op  <= a_in;
                ctr <= '0;
            end else if (run && carry_in) begin
                ctr <= ctr + NUM_BITS'(1);
            end
        end
    end

    // Stream bit is high for exactly op of the 2^NUM_BITS counter values
    assign s  = (op > ctr);
    assign tc = carry_in && (ctr == {NUM_BITS{1'b1}});

endmodule

// File: rtl/dsc_mul_n.sv
// rtl/dsc_mul_n.sv - N-input unsigned multiplier by exhaustive counting of stream-bit coincidences
module dsc_mul_n
    import dsc_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int NUM_BITS = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic [N_IN*NUM_BITS-1:0] a,
    output logic [N_IN*NUM_BITS-1:0] z,
    output logic                     ov,
    output logic                     busy
);

    localparam int W = N_IN * NUM_BITS;

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || NUM_BITS < NUM_BITS_MIN || NUM_BITS > NUM_BITS_MAX) begin : g_bad_param
        $error("dsc_mul_n: N_IN or NUM_BITS outside legal range");
    end

    dsc_state_t      state;
    dsc_state_t      state_next;
    logic [N_IN:0]   carry;
    logic [N_IN-1:0] s_bits;
    logic [N_IN-1:0] zero_ch;
    logic            accept;
    logic            in_run;
    logic            any_zero;
    logic            all_tc;
    logic            p;
    logic [W-1:0]    acc;

    assign in_run   = (state == ST_RUN);
    assign accept   = start && !in_run;
    assign carry[0] = 1'b1;
    assign all_tc   = carry[N_IN];
    assign p        = &s_bits;
    assign any_zero = |zero_ch;

    for (genvar g = 0; g < N_IN; g++) begin : g_ch
        dsc_prg_ch #(
            .NUM_BITS(NUM_BITS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .load    (accept),
            .run     (in_run),
            .carry_in(carry[g]),
            .a_in    (a[g*NUM_BITS +: NUM_BITS]),
            .s       (s_bits[g]),
            .tc      (carry[g+1])
        );
        assign zero_ch[g] = (a[g*NUM_BITS +: NUM_BITS] == '0);
    end

    // State register; a disabled cycle freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    // Next state: a zero operand short-cuts straight to DONE, RUN ends when every counter is at max
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = any_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (all_tc) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Accumulator counts the cycles where every stream bit is high, which equals the product
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            if (accept) begin
                acc <= '0;
            end else if (in_run) begin
                acc <= acc + W'(p);
            end
        end
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = (state == ST_RUN);
        ov   = (state == ST_DONE);
        z    = acc;
    end

endmodule

// File: doc/dsc_mul_n.md
DSC_MUL_N -- requirements
Module: dsc_mul_n

Interface
REQ-001 SHALL have parameter N_IN, default 2: number of multiplicand channels, legal range 2..4.
REQ-002 SHALL have parameter NUM_BITS, default 10: width of each unsigned operand, legal range 2..12.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1: global enable; when 0, all state holds.
REQ-006 SHALL have port start, input, 1: request to latch operands and begin an operation.
REQ-007 SHALL have port a, input, N_IN*NUM_BITS: packed operands; channel i occupies bits [i*NUM_BITS +: NUM_BITS].
REQ-008 SHALL have port z, output, N_IN*NUM_BITS: unsigned product of all channels.
REQ-009 SHALL have port ov, output, 1: result valid (operation finished).
REQ-010 SHALL have port busy, output, 1: high while in RUN.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE; busy = (state == RUN) and ov = (state == DONE).
REQ-012 SHALL accept start only in IDLE or DONE with en=1: latch a, clear all channel counters and the accumulator, clear ov, and go to RUN the next cycle.
REQ-013 SHALL ignore start while in RUN.
REQ-014 SHALL, when any latched operand equals 0 at start, go to DONE instead of RUN, with z=0 and ov=1 on the following cycle.
REQ-015 SHALL keep one NUM_BITS-bit counter ctr_i per channel and use clock-division ordering: ctr_0 increments every enabled RUN cycle, and ctr_i increments only when ctr_0..ctr_(i-1) are all at the maximum value 2^NUM_BITS-1.
REQ-016 SHALL form the stream bit s_i = (a_i > ctr_i) per channel and the product bit p = AND of all s_i.
REQ-017 SHALL add p to an N_IN*NUM_BITS-bit accumulator every enabled RUN cycle; the accumulator never overflows, because its maximum value (2^NUM_BITS-1)^N_IN fits the width.
REQ-018 SHALL run for exactly 2^(N_IN*NUM_BITS) enabled cycles; the cycle in which all counters are at maximum is the last RUN cycle, and the next state is DONE.
REQ-019 SHALL drive z as the accumulator register; in DONE, z equals the exact product of a_0..a_(N_IN-1).
REQ-020 SHALL hold z and ov in DONE until rst or an accepted start.
REQ-021 SHALL, when en=0 in any state, freeze state, counters, accumulator and outputs; an en=0 gap never changes the result.
REQ-022 SHALL ignore changes on a after the operands are latched.

Reset
REQ-023 SHALL, on rst=1 at a rising clk edge, enter IDLE, clear all counters and latched operands, and drive z=0, ov=0, busy=0.
REQ-024 SHALL let rst take priority over en and start, and SHALL abort an in-flight RUN with no partial result retained.

Structure
REQ-025 SHALL place the FSM state encoding and the N_IN and NUM_BITS legal-range constants in the shared package dsc_pkg.
REQ-026 SHALL implement one channel as sub-module dsc_prg_ch: the channel counter, the carry-in/terminal-count chain and the a_i > ctr_i comparator. dsc_mul_n instantiates it N_IN times via generate, chaining terminal counts.
REQ-027 SHALL keep the accumulator and the FSM in dsc_mul_n itself.

Verification
REQ-028 SHALL check, with N_IN=2, NUM_BITS=10, a=(15,15), start pulse: busy for exactly 1,048,576 enabled cycles, then ov=1 and z=225.
REQ-029 SHALL check, with N_IN=2, a=(1023,1023): z=1,046,529 with ov held high.
REQ-030 SHALL check, with N_IN=2, a=(0,700): ov=1 and z=0 two cycles after start, and busy never asserts.
REQ-031 SHALL check, with N_IN=3, NUM_BITS=4, a=(15,7,3): 4096 RUN cycles, then z=315; a start pulsed mid-RUN is ignored.
REQ-032 SHALL check random en=0 gaps during RUN with a=(513,77): z=39,501, and the RUN length in enabled cycles is unchanged.
REQ-033 SHALL check rst asserted mid-RUN: the next cycle shows IDLE with z=0 and ov=0, and a following start with a=(3,5) yields z=15.
